// File: rtl/st_pkt_source_pkg.sv
// st_pkt_source_pkg: shared types and constants for the packet source.
// FSM state encoding, PRBS-31 tap/width constants, zero-seed substitute,
// and the LFSR step function.
package st_pkt_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // PRBS-31, polynomial x^31 + x^28 + 1, Fibonacci form.
  localparam int PRBS_W      = 31;
  localparam int PRBS_TAP_HI = 30;  // x^31 term, bit index
  localparam int PRBS_TAP_LO = 27;  // x^28 term, bit index

  // An all-zero LFSR would lock up, so a zero seed is replaced by this.
  localparam logic [PRBS_W-1:0] PRBS_ZERO_SEED = 31'd1;

  // One LFSR step: shift left, feed back the XOR of the two taps.
  function automatic logic [PRBS_W-1:0] prbs31_next(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
  endfunction

endpackage

// File: rtl/st_pkt_pattern_gen.sv
// st_pkt_pattern_gen: data-word register for the packet source.
// Holds both the incrementing counter and the PRBS-31 LFSR; 'sel' picks
// which one drives 'word'. 'load' reseeds, 'advance' steps once per
// transferred beat. DATA_WIDTH must exceed the 31-bit LFSR width.
module st_pkt_pattern_gen
  import st_pkt_source_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  advance,
  input  logic                  sel,
  output logic [DATA_WIDTH-1:0] word
);

  logic [DATA_WIDTH-1:0] inc_q;
  logic [PRBS_W-1:0]     lfsr_q;
  logic [PRBS_W-1:0]     lfsr_seed;

  assign lfsr_seed = (seed[PRBS_W-1:0] == '0) ? PRBS_ZERO_SEED : seed[PRBS_W-1:0];

  // Seed on load, otherwise step both generators on every transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inc_q  <= '0;
      lfsr_q <= '0;
    end else if (load) begin
      inc_q  <= seed;
      lfsr_q <= lfsr_seed;
    end else if (advance) begin
      inc_q  <= inc_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      lfsr_q <= prbs31_next(lfsr_q);
    end
  end

  // Zero-extended LFSR state or the incrementing word.
  always_comb begin
    word = inc_q;
    if (sel) word = {{(DATA_WIDTH-PRBS_W){1'b0}}, lfsr_q};
  end

endmodule

// File: rtl/st_pkt_source.sv
// st_pkt_source: Avalon-ST packet generator (source side).
// Emits pkt_count packets of max(pkt_len,1) beats, starting from seed,
// with IPG idle cycles between packets. Optional macro
// ST_PKT_SOURCE_PRBS_EN adds a pattern_sel input choosing PRBS-31 data.
//
// Handshake: a beat transfers on a rising clk edge where aso_valid &&
// aso_ready (readyLatency 0). Once aso_valid is high it stays high, and
// aso_data / aso_startofpacket / aso_endofpacket stay stable, until that
// beat transfers; only reset can withdraw a presented beat.
module st_pkt_source
  import st_pkt_source_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 16,
  parameter int CNT_W      = 16,
  parameter int IPG        = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_W-1:0]      pkt_len,
  input  logic [CNT_W-1:0]      pkt_count,
  input  logic [DATA_WIDTH-1:0] seed,
`ifdef ST_PKT_SOURCE_PRBS_EN
  input  logic                  pattern_sel,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  aso_valid,
  output logic [DATA_WIDTH-1:0] aso_data,
  output logic                  aso_startofpacket,
  output logic                  aso_endofpacket,
  input  logic                  aso_ready
);

  localparam int GAP_W = (IPG > 1) ? $clog2(IPG) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IPG > 0) ? IPG - 1 : 0);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_eff_q, len_eff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             abort_q, abort_d;
  logic             load;
  logic             pat_sel;
  logic             is_eop;
  logic             is_last;
  logic             abort_now;

  // abort is a request: once seen during a run it is held until the run ends.
  assign abort_now = abort_q | abort;
  assign is_eop    = (beat_q == len_eff_q - LEN_W'(1));
  assign is_last   = (pkt_q == cnt_q - CNT_W'(1));

  // State and run-control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      len_eff_q <= '0;
      cnt_q     <= '0;
      beat_q    <= '0;
      pkt_q     <= '0;
      gap_q     <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_eff_q <= len_eff_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      pkt_q     <= pkt_d;
      gap_q     <= gap_d;
      abort_q   <= abort_d;
    end
  end

  // Next-state, counter and latch logic.
  always_comb begin
    state_d   = state_q;
    len_eff_d = len_eff_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    pkt_d     = pkt_q;
    gap_d     = gap_q;
    abort_d   = abort_q;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          len_eff_d = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
          cnt_d     = pkt_count;
          beat_d    = '0;
          pkt_d     = '0;
          gap_d     = '0;
          abort_d   = abort;
          load      = 1'b1;
          state_d   = (pkt_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        abort_d = abort_now;
        if (aso_ready) begin
          if (is_eop) begin
            beat_d = '0;
            if (is_last || abort_now) begin
              state_d = ST_DONE;
            end else begin
              pkt_d   = pkt_q + CNT_W'(1);
              gap_d   = '0;
              state_d = (IPG > 0) ? ST_GAP : ST_RUN;
            end
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      ST_GAP: begin
        abort_d = abort_now;
        if (abort_now) begin
          state_d = ST_DONE;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_RUN;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_DONE: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ST_PKT_SOURCE_PRBS_EN
  logic sel_q;
  // Pattern choice is captured with the other run parameters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          sel_q <= 1'b0;
    else if (state_q == ST_IDLE && start)  sel_q <= pattern_sel;
  end
  assign pat_sel = sel_q;
`else
  assign pat_sel = 1'b0;
`endif

  assign aso_valid         = (state_q == ST_RUN);
  assign aso_startofpacket = aso_valid && (beat_q == '0);
  assign aso_endofpacket   = aso_valid && is_eop;
  assign busy              = (state_q != ST_IDLE);
  assign done              = (state_q == ST_DONE);

  st_pkt_pattern_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pattern (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load),
    .seed   (seed),
    .advance(aso_valid && aso_ready),
    .sel    (pat_sel),
    .word   (aso_data)
  );

endmodule

// File: tb/tb_st_pkt_source.sv
// tb_st_pkt_source: randomized self-checking bench for st_pkt_source.
// Two instances share stimulus: u_dut0 with IPG=0, u_dut1 with IPG=2;
// sel_dut chooses which one the monitor checks.
module tb_st_pkt_source;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int CW = 16;
  localparam int BW = DW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          aso_ready = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic [CW-1:0] pkt_count = '0;
  logic [DW-1:0] seed = '0;
`ifdef ST_PKT_SOURCE_PRBS_EN
  logic          pattern_sel = 1'b0;
`endif

  logic          busy0, done0, v0, sop0, eop0;
  logic [DW-1:0] d0;
  logic          busy1, done1, v1, sop1, eop1;
  logic [DW-1:0] d1;

  st_pkt_source #(.DATA_WIDTH(DW), .LEN_W(LW), .CNT_W(CW), .IPG(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .pkt_len(pkt_len), .pkt_count(pkt_count), .seed(seed),
`ifdef ST_PKT_SOURCE_PRBS_EN
    .pattern_sel(pattern_sel),
`endif
    .busy(busy0), .done(done0), .aso_valid(v0), .aso_data(d0),
    .aso_startofpacket(sop0), .aso_endofpacket(eop0), .aso_ready(aso_ready)
  );

  st_pkt_source #(.DATA_WIDTH(DW), .LEN_W(LW), .CNT_W(CW), .IPG(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .pkt_len(pkt_len), .pkt_count(pkt_count), .seed(seed),
`ifdef ST_PKT_SOURCE_PRBS_EN
    .pattern_sel(pattern_sel),
`endif
    .busy(busy1), .done(done1), .aso_valid(v1), .aso_data(d1),
    .aso_startofpacket(sop1), .aso_endofpacket(eop1), .aso_ready(aso_ready)
  );

  int sel_dut = 0;
  int cur_ipg = 0;
  logic          m_valid, m_sop, m_eop, m_busy, m_done;
  logic [DW-1:0] m_data;
  assign m_valid = (sel_dut != 0) ? v1    : v0;
  assign m_sop   = (sel_dut != 0) ? sop1  : sop0;
  assign m_eop   = (sel_dut != 0) ? eop1  : eop0;
  assign m_busy  = (sel_dut != 0) ? busy1 : busy0;
  assign m_done  = (sel_dut != 0) ? done1 : done0;
  assign m_data  = (sel_dut != 0) ? d1    : d0;

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- ready driver ----------------
  // mode 0: always ready, 1: repeating 1,0,0,1, 2: random
  int ready_mode = 0;
  int ready_ph = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: aso_ready = 1'b1;
        1: begin
          aso_ready = ((ready_ph % 4) == 0) || ((ready_ph % 4) == 3);
          ready_ph++;
        end
        default: aso_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  // Expected beats are {sop, eop, data}.
  logic [BW-1:0] exp_q[$];
  bit            mon_en = 1'b0;
  bit            run_finished = 1'b0;
  bit            exp_done_now = 1'b0;
  bit            exp_idle_now = 1'b0;
  bit            waiting_sop = 1'b0;
  bit            prev_stall = 1'b0;
  logic [BW-1:0] prev_beat = '0;
  int            gap_seen = 0;
  int            xfers = 0;

  always @(negedge clk) begin
    logic [BW-1:0] act_beat;
    logic [BW-1:0] exp_beat;
    if (mon_en) begin
      act_beat = {m_sop, m_eop, m_data};
      if (exp_idle_now) begin
        chk_eq("busy_fall", m_busy, 0);
        exp_idle_now = 1'b0;
        run_finished = 1'b1;
      end
      chk_eq("done", m_done, exp_done_now);
      if (exp_done_now) begin
        chk_eq("busy_at_done", m_busy, 1);
        chk_eq("valid_at_done", m_valid, 0);
        exp_done_now = 1'b0;
        exp_idle_now = 1'b1;
      end
      if (prev_stall) begin
        chk_eq("stall_valid", m_valid, 1);
        chk_eq("stall_hold", act_beat, prev_beat);
      end
      if (waiting_sop && m_valid) begin
        chk_eq("ipg_len", gap_seen, cur_ipg);
        waiting_sop = 1'b0;
      end else if (waiting_sop) begin
        gap_seen++;
      end
      prev_stall = m_valid && !aso_ready;
      prev_beat  = act_beat;
      if (m_valid && aso_ready) begin
        if (exp_q.size() == 0) begin
          chk_eq("extra_beat", act_beat, 0);
        end else begin
          exp_beat = exp_q.pop_front();
          chk_eq("beat", act_beat, exp_beat);
          xfers++;
          if (exp_q.size() == 0) exp_done_now = 1'b1;
          else if (exp_beat[BW-2]) begin
            waiting_sop = 1'b1;
            gap_seen = 0;
          end
        end
      end
    end
  end

  // ---------------- run driver ----------------
  // abort_at: transfer index during which abort is raised (-1 = never).
  task automatic run_pkt(input int len, input int cnt, input logic [DW-1:0] sd,
                         input int abort_at, input bit mid_start);
    int le;
    int npk;
    int budget;
    logic [DW-1:0] d;
    le  = (len == 0) ? 1 : len;
    npk = cnt;
    if (abort_at >= 0 && (abort_at / le + 1) < npk) npk = abort_at / le + 1;
    d = sd;
    for (int p = 0; p < npk; p++) begin
      for (int b = 0; b < le; b++) begin
        exp_q.push_back({(b == 0), (b == le - 1), d});
        d = d + 1;
      end
    end
    xfers = 0; run_finished = 0; exp_done_now = 0; exp_idle_now = 0;
    waiting_sop = 0; prev_stall = 0; mon_en = 1;
    cur_ipg = (sel_dut != 0) ? 2 : 0;
    @(posedge clk); #1;
    pkt_len = LW'(len); pkt_count = CW'(cnt); seed = sd; start = 1'b1;
    if (abort_at == 0) abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pkt_len = LW'($urandom); pkt_count = CW'($urandom); seed = $urandom;
    if (cnt == 0) exp_done_now = 1'b1;
    @(negedge clk);
    chk_eq("first_valid", m_valid, (cnt != 0));
    if (cnt != 0) chk_eq("first_sop", m_sop, 1);
    budget = 0;
    while (!run_finished && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
      if (abort_at >= 0 && xfers >= abort_at) abort = 1'b1;
      start = mid_start && (budget == 5);
    end
    if (!run_finished) chk_eq("run_timeout", 0, 1);
    chk_eq("exp_q_empty", exp_q.size(), 0);
    chk_eq("xfer_total", xfers, npk * le);
    abort = 1'b0; start = 1'b0; mon_en = 1'b0;
    exp_q.delete();
    budget = 0;
    while ((busy0 || busy1) && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk_eq({tag, "_valid0"}, v0, 0);
    chk_eq({tag, "_valid1"}, v1, 0);
    chk_eq({tag, "_sop"}, sop0, 0);
    chk_eq({tag, "_eop"}, eop0, 0);
    chk_eq({tag, "_busy"}, busy0, 0);
    chk_eq({tag, "_done"}, done0, 0);
    chk_eq({tag, "_data"}, d0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // basic back-to-back run
    sel_dut = 0; ready_mode = 0;
    run_pkt(4, 2, 32'h10, -1, 0);
    // 1,0,0,1 backpressure
    ready_mode = 1; ready_ph = 0;
    run_pkt(4, 2, 32'h10, -1, 0);
    // zero length and zero count
    ready_mode = 0;
    run_pkt(0, 3, 32'h1234, -1, 0);
    run_pkt(4, 0, 32'h99, -1, 0);
    // data wrap
    run_pkt(3, 1, 32'hFFFF_FFFE, -1, 0);
    // abort in packet 1 beat 2 with random stalls, plus a start mid-run
    ready_mode = 2;
    run_pkt(5, 10, $urandom, 7, 1);
    // start and abort together
    run_pkt(3, 4, $urandom, 0, 0);
    // inter-packet gap
    sel_dut = 1; ready_mode = 0;
    run_pkt(2, 2, 32'h40, -1, 0);
    ready_mode = 2;
    run_pkt(2, 3, 32'h80, -1, 0);

    // reset in the middle of a packet
    sel_dut = 0; ready_mode = 0;
    @(posedge clk); #1;
    pkt_len = 4; pkt_count = 2; seed = 32'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk_eq("pre_reset_valid", v0, 1);
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("mid_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_pkt(4, 2, 32'hA0, -1, 0);

    // randomized runs
    ready_mode = 2;
    for (int i = 0; i < 8; i++) begin
      sel_dut = int'($urandom_range(0, 1));
      run_pkt(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), $urandom, -1, 0);
    end
    sel_dut = 0;
    for (int i = 0; i < 3; i++) begin
      run_pkt(int'($urandom_range(1, 4)), int'($urandom_range(2, 5)), $urandom,
              int'($urandom_range(0, 6)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
